dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the rv32 core; successor to the fixed 256-word byte-masked RAM.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_ctrl_if.sv | 28 ++
 rtl/dmem_lane_align.sv | 65 ++++++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the rv32 data-memory controller: access sizes,
// controller FSM states and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the core MEM stage (master) and dmem_ctrl (slave).
//
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// a response transfers on an edge where rsp_valid && rsp_ready. Once raised,
// rsp_valid and all rsp_* fields stay stable until the response transfers.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: builds store lane masks and replicated
// store data, extracts and sign/zero-extends load data, flags misalignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Store side: lane mask and data replicated onto every candidate lane.
    always_comb begin
        wmask       = 4'b0000;
        wdata_lanes = 32'h0;
        case (size)
            SZ_B: begin
                wmask       = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_H: begin
                wmask       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            SZ_W: begin
                wmask       = 4'b1111;
                wdata_lanes = wdata;
            end
            default: begin
                wmask       = 4'b0000;
                wdata_lanes = 32'h0;
            end
        endcase
    end

    // Load side: pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        rbyte = rword[8*addr_lo +: 8];
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B:    rdata = {{24{rbyte[7] & ~is_unsigned}}, rbyte};
            SZ_H:    rdata = {{16{rhalf[15] & ~is_unsigned}}, rhalf};
            SZ_W:    rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

    // Natural-alignment check; only consulted when misalign errors are enabled.
    always_comb begin
        case (size)
            SZ_H:    misalign = addr_lo[0];
            SZ_W:    misalign = (addr_lo != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the rv32 core: byte/half/word loads and stores
// over a valid/ready bus, configurable wait-state latency, on-chip RAM array.
// Optional feature macro: DMEM_MISALIGN_ERR_EN -- when defined, misaligned
// half/word accesses are rejected with rsp_err; otherwise their low address
// bits are forced aligned and the access proceeds.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_ctrl_if.slave    bus,
    output dmem_state_e   dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e           state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Request captured at acceptance.
    logic                  cap_we;
    mem_size_e             cap_size;
    logic                  cap_unsigned;
    logic [AW+1:0]         cap_addr;

    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic [31:0]           mem [DEPTH_WORDS];

    // Effective request: live inputs while IDLE (acceptance edge), captured otherwise.
    logic                  idle;
    logic                  eff_we;
    mem_size_e             eff_size;
    logic                  eff_unsigned;
    logic [AW+1:0]         eff_addr;
    logic [31:0]           rword;
    logic [3:0]            wmask;
    logic [31:0]           wdata_lanes;
    logic [31:0]           ext_rdata;
    logic                  misalign;
    logic                  err_now;
    logic [31:0]           rsp_data_now;
    logic                  accept;
    logic                  unused_addr_hi;

    assign idle         = (state == IDLE);
    assign eff_we       = idle ? bus.req_we : cap_we;
    assign eff_size     = idle ? mem_size_e'(bus.req_size) : cap_size;
    assign eff_unsigned = idle ? bus.req_unsigned : cap_unsigned;
    assign eff_addr     = idle ? bus.req_addr[AW+1:0] : cap_addr;
    assign rword        = mem[eff_addr[AW+1:2]];

    // Upper address bits are ignored so the address space wraps.
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    dmem_lane_align u_align (
        .size        (eff_size),
        .addr_lo     (eff_addr[1:0]),
        .is_unsigned (eff_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (rword),
        .wmask       (wmask),
        .wdata_lanes (wdata_lanes),
        .rdata       (ext_rdata),
        .misalign    (misalign)
    );

`ifdef DMEM_MISALIGN_ERR_EN
    assign err_now = (eff_size == SZ_RSVD) || misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign err_now         = (eff_size == SZ_RSVD);
`endif

    assign rsp_data_now = (eff_we || err_now) ? 32'h0 : ext_rdata;
    assign accept       = rst_n && idle && bus.req_valid;

    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state;

    // Controller FSM: accept, optional wait states, hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cap_we       <= 1'b0;
            cap_size     <= SZ_B;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_we       <= bus.req_we;
                        cap_size     <= mem_size_e'(bus.req_size);
                        cap_unsigned <= bus.req_unsigned;
                        cap_addr     <= bus.req_addr[AW+1:0];
                        if (WAIT_STATES == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_data_now;
                            rsp_err_q   <= err_now;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_data_now;
                        rsp_err_q   <= err_now;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM write port: stores land on the acceptance edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !err_now) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[eff_addr[AW+1:2]][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl (DEPTH_WORDS=256, WAIT_STATES=2): directed load/store
// vectors with hand-computed responses, scoreboard queue plus response monitor.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int WS = 2;

  logic        clk;
  logic        rst_n;
  dmem_state_e dbg_state;
  dmem_ctrl_if bus ();

  dmem_ctrl #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int acc_cyc = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver: present one request, wait for acceptance, then scramble inputs
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input logic push);
    int n = 0;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      $display("FAIL req_accept_timeout: req_ready=0 after %0d cycles, required 1", n);
      bus.req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (push) exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom_range(0, 1));
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_unsigned = 1'($urandom_range(0, 1));
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  // scoreboard monitor: latency of first valid, then data/err on transfer
  logic seen = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        check("rsp_latency", 32'(cyc + 1 - acc_cyc), 32'(WS + 1));
      end
      if (bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: rdata=0x%08h err=%0b, required no response", bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e[31:0]);
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e[32]});
        end
        seen = 1'b0;
      end
    end
  end

  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, R = 2'd3;

  initial begin
    logic [31:0] snap_d;
    logic        snap_e;
    int          n;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;
    rst_n            = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-WAIT: accepted store stays written, response is discarded
    send(1'b1, W, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
    check("mid_wait_state", {30'b0, dbg_state}, {30'b0, WAIT});
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    send(1'b0, W, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);

    // byte/half store-load with sign/zero extension
    send(1'b1, W, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    send(1'b0, B, 1'b0, 32'h3, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b1);
    send(1'b0, B, 1'b1, 32'h3, 32'h0, 32'h000000DE, 1'b0, 1'b1);
    send(1'b0, H, 1'b0, 32'h0, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1);
    send(1'b0, H, 1'b1, 32'h2, 32'h0, 32'h0000DEAD, 1'b0, 1'b1);
    send(1'b0, W, 1'b1, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // lane masking
    send(1'b1, W, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 1'b1);
    send(1'b1, B, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 1'b1);
    send(1'b1, H, 1'b0, 32'h12, 32'h00005566, 32'h0, 1'b0, 1'b1);
    send(1'b0, W, 1'b0, 32'h10, 32'h0, 32'h5566AA44, 1'b0, 1'b1);

    // backpressure: response held stable while rsp_ready=0
    drain();
    bus.rsp_ready = 1'b0;
    send(1'b0, B, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    snap_d = bus.rsp_rdata;
    snap_e = bus.rsp_err;
    check("bp_rdata_value", snap_d, 32'hFFFFFFAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("bp_hold_rdata", bus.rsp_rdata, snap_d);
      check("bp_hold_err", {31'b0, bus.rsp_err}, {31'b0, snap_e});
      check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    drain();

    // misalignment
    send(1'b1, W, 1'b0, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
`ifdef DMEM_MISALIGN_ERR_EN
    send(1'b0, W, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1'b1);
    send(1'b1, H, 1'b0, 32'h1, 32'h00007777, 32'h0, 1'b1, 1'b1);
    send(1'b0, W, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
`else
    send(1'b0, W, 1'b0, 32'h6, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    send(1'b1, H, 1'b0, 32'h1, 32'h00007777, 32'h0, 1'b0, 1'b1);
    send(1'b0, W, 1'b0, 32'h0, 32'h0, 32'hDEAD7777, 1'b0, 1'b1);
`endif

    // address wrap and reserved size
    send(1'b1, W, 1'b0, 32'h400, 32'h00000001, 32'h0, 1'b0, 1'b1);
    send(1'b0, W, 1'b0, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b1);
    send(1'b1, R, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    send(1'b0, R, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    send(1'b0, W, 1'b0, 32'h0, 32'h0, 32'h00000001, 1'b0, 1'b1);

    drain();
    repeat (4) @(negedge clk);
    check("end_state", {30'b0, dbg_state}, {30'b0, IDLE});
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
